// File: rtl/pixlcd_pkg.sv
// Shared types for the page-organised pixel LCD frame buffer: command ops,
// FSM states, page geometry and the pixel read-modify-write helper.
package pixlcd_pkg;

    localparam int PAGE_ROWS = 8;

    typedef enum logic [1:0] {
        FB_SET  = 2'd0,
        FB_CLR  = 2'd1,
        FB_TGL  = 2'd2,
        FB_FILL = 2'd3
    } t_fb_op;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_FILL
    } t_fb_state;

    function automatic logic [7:0] fb_apply(input logic [7:0] word,
                                            input logic [2:0] bit_idx,
                                            input t_fb_op     op);
        logic [7:0] mask;
        logic [7:0] res;
        mask = 8'h01 << bit_idx;
        case (op)
            FB_SET:  res = word | mask;
            FB_CLR:  res = word & ~mask;
            default: res = word ^ mask;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pixlcd_fb_ram.sv
// Simple dual-port byte RAM: write port A, registered read port B returning
// old data on a same-address read-during-write.
module pixlcd_fb_ram #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixlcd_framebuf.sv
// Pixel frame buffer feeding the pixel LCD controller: set/clear/toggle by
// read-modify-write, whole-screen fill. PIXLCD_FB_CLEAR_ON_RESET_EN clears the buffer on reset exit.
module pixlcd_framebuf
    import pixlcd_pkg::*;
#(
    parameter int LCD_COLS  = 128,
    parameter int LCD_PAGES = 8,
    parameter int COL_BITS  = $clog2(LCD_COLS),
    parameter int PAGE_BITS = $clog2(LCD_PAGES),
    parameter int ADDR_BITS = $clog2(LCD_COLS*LCD_PAGES)
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_cmd_valid,
    output logic                 out_cmd_ready,
    input  logic [1:0]           in_cmd_op,
    input  logic [COL_BITS-1:0]  in_cmd_x,
    input  logic [PAGE_BITS+2:0] in_cmd_y,
    input  logic [7:0]           in_fill_word,
    input  logic [ADDR_BITS-1:0] in_mem_addr,
    output logic [7:0]           out_mem_word,
    output logic                 out_busy
);

    localparam int DEPTH    = LCD_COLS * LCD_PAGES;
    localparam int ROW_BITS = $clog2(PAGE_ROWS);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

`ifdef PIXLCD_FB_CLEAR_ON_RESET_EN
    localparam t_fb_state RST_STATE = ST_FILL;
`else
    localparam t_fb_state RST_STATE = ST_IDLE;
`endif

    t_fb_state            state, state_next;
    t_fb_op               op_q;
    logic [COL_BITS-1:0]  x_q;
    logic [PAGE_BITS+2:0] y_q;
    logic [7:0]           fill_q;
    logic [ADDR_BITS-1:0] cnt;
    logic                 accept, in_range, we;
    logic [PAGE_BITS-1:0] page;
    logic [ADDR_BITS-1:0] pix_addr, waddr;
    logic [7:0]           wdata, rmw_word;

    assign page     = y_q[PAGE_BITS+ROW_BITS-1:ROW_BITS];
    assign pix_addr = ADDR_BITS'(int'(page) * LCD_COLS + int'(x_q));
    assign in_range = (int'(x_q) < LCD_COLS) && (int'(page) < LCD_PAGES);

    assign out_cmd_ready = (state == ST_IDLE);
    // Gated by reset so busy stays low while reset is held, even when
    // reset parks the FSM in FILL.
    assign out_busy      = in_rst && (state != ST_IDLE);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) state <= RST_STATE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        we         = 1'b0;
        waddr      = pix_addr;
        wdata      = fb_apply(rmw_word, y_q[ROW_BITS-1:0], op_q);
        case (state)
            ST_IDLE: begin
                if (in_cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (t_fb_op'(in_cmd_op) == FB_FILL) ? ST_FILL : ST_RMW_RD;
                end
            end
            ST_RMW_RD: state_next = ST_RMW_WR;
            ST_RMW_WR: begin
                we         = in_range;
                state_next = ST_IDLE;
            end
            ST_FILL: begin
                we    = 1'b1;
                waddr = cnt;
                wdata = fill_q;
                if (cnt == LAST_ADDR) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset values double as the clear-on-reset fill setup (word 0, address 0).
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            op_q   <= FB_SET;
            x_q    <= '0;
            y_q    <= '0;
            fill_q <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= t_fb_op'(in_cmd_op);
            x_q    <= in_cmd_x;
            y_q    <= in_cmd_y;
            fill_q <= in_fill_word;
            cnt    <= '0;
        end else if (state == ST_FILL && cnt != LAST_ADDR) begin
            cnt <= cnt + ADDR_BITS'(1);
        end
    end

    // Two copies written in lockstep: one serves the LCD read port, the
    // other the RMW read, so the LCD side never loses a read slot.
    pixlcd_fb_ram #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) u_lcd_ram (
        .clk   (in_clk),
        .rst_n (in_rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (in_mem_addr),
        .rdata (out_mem_word)
    );

    pixlcd_fb_ram #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) u_rmw_ram (
        .clk   (in_clk),
        .rst_n (in_rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (pix_addr),
        .rdata (rmw_word)
    );

endmodule

// File: tb/tb_pixlcd_framebuf.sv
// Bench for pixlcd_framebuf with widened coordinate ports; random and directed
// commands checked against a byte-array model of the display.
module tb_pixlcd_framebuf;

    localparam int COLS  = 128;
    localparam int PAGES = 8;
    localparam int CB    = 8;
    localparam int PB    = 4;
    localparam int AB    = 10;
    localparam int DEPTH = COLS * PAGES;

    logic          in_clk = 1'b0;
    logic          in_rst = 1'b0;
    logic          in_cmd_valid = 1'b0;
    logic          out_cmd_ready;
    logic [1:0]    in_cmd_op = '0;
    logic [CB-1:0] in_cmd_x = '0;
    logic [PB+2:0] in_cmd_y = '0;
    logic [7:0]    in_fill_word = '0;
    logic [AB-1:0] in_mem_addr = '0;
    logic [7:0]    out_mem_word;
    logic          out_busy;

    logic [7:0] model [DEPTH];
    logic [7:0] saved [DEPTH];
    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc = 0;
    int n, st;
    logic [7:0] w;

    pixlcd_framebuf #(.LCD_COLS(COLS), .LCD_PAGES(PAGES), .COL_BITS(CB),
                      .PAGE_BITS(PB), .ADDR_BITS(AB)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_cmd_valid  (in_cmd_valid),
        .out_cmd_ready (out_cmd_ready),
        .in_cmd_op     (in_cmd_op),
        .in_cmd_x      (in_cmd_x),
        .in_cmd_y      (in_cmd_y),
        .in_fill_word  (in_fill_word),
        .in_mem_addr   (in_mem_addr),
        .out_mem_word  (out_mem_word),
        .out_busy      (out_busy)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Display model: pixel (x,y) lives in byte (y/8)*COLS+x, bit y%8.
    task automatic model_apply(input int op, input int x, input int y, input int fw);
        int a, b;
        if (op == 3) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 8'(fw);
        end else if (x < COLS && (y / 8) < PAGES) begin
            a = (y / 8) * COLS + x;
            b = y % 8;
            case (op)
                0: model[a][b] = 1'b1;
                1: model[a][b] = 1'b0;
                default: model[a][b] = ~model[a][b];
            endcase
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!out_cmd_ready && k < 3000) begin
            @(negedge in_clk);
            k++;
        end
        if (!out_cmd_ready) chk("idle_timeout", 32'(out_cmd_ready), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input int op, input int x, input int y, input int fw);
        wait_idle();
        if (!out_cmd_ready) return;
        in_cmd_valid = 1'b1;
        in_cmd_op    = 2'(op);
        in_cmd_x     = CB'(x);
        in_cmd_y     = 7'(y);
        in_fill_word = 8'(fw);
        @(negedge in_clk);
        prev_acc     = acc_cyc;
        acc_cyc      = cyc;
        in_cmd_valid = 1'b0;
        in_cmd_op    = 2'($urandom);
        in_cmd_x     = CB'($urandom);
        in_cmd_y     = 7'($urandom);
        in_fill_word = 8'($urandom);
        model_apply(op, x, y, fw);
    endtask

    task automatic read_chk(input int a, input string tag);
        in_mem_addr = AB'(a);
        @(negedge in_clk);
        chk($sformatf("%s@%0d", tag, a), 32'(out_mem_word), 32'(model[a]));
    endtask

    task automatic full_cmp(input string tag);
        for (int a = 0; a < DEPTH; a++) read_chk(a, tag);
    endtask

    initial begin
        repeat (3) @(negedge in_clk);
        chk("rst_word", 32'(out_mem_word), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
`ifdef PIXLCD_FB_CLEAR_ON_RESET_EN
        chk("rst_ready", 32'(out_cmd_ready), 32'd0);
        in_rst = 1'b1;
        #1;
        chk("clr_busy", 32'(out_busy), 32'd1);
        n = 0;
        while (!out_cmd_ready && n < 3000) begin
            @(negedge in_clk);
            n++;
        end
        chk("clr_len", 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
`else
        chk("rst_ready", 32'(out_cmd_ready), 32'd1);
        @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);
        send_cmd(3, 0, 0, 8'h3C);
        wait_idle();
`endif
        full_cmp("init");

        // Set then toggle pixel (5,11) on a dark screen.
        send_cmd(3, 0, 0, 8'h00);
        send_cmd(0, 5, 11, 0);
        repeat (2) @(negedge in_clk);
        read_chk(133, "set_px");
        chk("set_px_abs", 32'(out_mem_word), 32'h08);
        send_cmd(2, 5, 11, 0);
        repeat (2) @(negedge in_clk);
        read_chk(133, "tgl_px");
        chk("tgl_px_abs", 32'(out_mem_word), 32'h00);
        send_cmd(1, 5, 11, 0);
        send_cmd(2, 5, 11, 0);
        chk("acc_gap", 32'(acc_cyc - prev_acc), 32'd3);
        wait_idle();
        read_chk(133, "clr_tgl_px");

        // Read-during-write at address 40 (x=40, row 2).
        send_cmd(0, 40, 2, 0);
        @(negedge in_clk);
        in_mem_addr = AB'(40);
        @(negedge in_clk);
        chk("rdw_old", 32'(out_mem_word), 32'h00);
        @(negedge in_clk);
        chk("rdw_new", 32'(out_mem_word), 32'(model[40]));

        // Fill with a command held off until ready rises.
        send_cmd(3, 0, 0, 8'hA5);
        st = acc_cyc;
        in_cmd_valid = 1'b1;
        in_cmd_op    = 2'd0;
        in_cmd_x     = CB'(7);
        in_cmd_y     = 7'(20);
        n = 0;
        while (!out_cmd_ready && n < 3000) begin
            @(negedge in_clk);
            n++;
        end
        chk("fill_hold", 32'(n), 32'(DEPTH));
        @(negedge in_clk);
        chk("fill_acc_gap", 32'(cyc - st), 32'(DEPTH + 1));
        in_cmd_valid = 1'b0;
        model_apply(0, 7, 20, 0);
        wait_idle();
        read_chk(0, "fill");
        chk("fill0_abs", 32'(out_mem_word), 32'hA5);
        read_chk(511, "fill");
        chk("fill511_abs", 32'(out_mem_word), 32'hA5);
        read_chk(1023, "fill");
        chk("fill1023_abs", 32'(out_mem_word), 32'hA5);
        read_chk(263, "held_px");

        // Out-of-range commands are accepted but write nothing.
        send_cmd(0, 200, 3, 0);
        chk("oor_busy", 32'(out_busy), 32'd1);
        send_cmd(2, 10, 70, 0);
        send_cmd(1, 130, 127, 0);
        wait_idle();
        full_cmp("oor");

        for (int i = 0; i < 60; i++) begin
            int op, x, y, a;
            op = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            x  = int'($urandom_range(0, 159));
            y  = int'($urandom_range(0, 79));
            send_cmd(op, x, y, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                a = int'($urandom_range(0, DEPTH - 1));
                read_chk(a, "rand_spot");
            end
        end
        wait_idle();
        full_cmp("rand");

        // Reset while the fill is about to write address 300.
        send_cmd(3, 0, 0, 8'h00);
        wait_idle();
        for (int i = 0; i < DEPTH; i++) saved[i] = model[i];
        w = 8'($urandom) | 8'h01;
        in_mem_addr = AB'(5);
        send_cmd(3, 0, 0, int'(w));
        repeat (300) @(negedge in_clk);
        chk("pre_rst_word", 32'(out_mem_word), 32'(w));
        chk("pre_rst_busy", 32'(out_busy), 32'd1);
        in_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(out_busy), 32'd0);
        chk("mid_rst_word", 32'(out_mem_word), 32'd0);
        for (int i = 300; i < DEPTH; i++) model[i] = saved[i];
        @(negedge in_clk);
        in_rst = 1'b1;
`ifdef PIXLCD_FB_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
`endif
        wait_idle();
        full_cmp("post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
